// File: rtl/gf256mul_dec_if.sv
// Operand/result bundle for the GF(2^8) multiplier: the bench side drives operands, the multiplier returns products.
// There is no handshake; in_val only qualifies the registered product path.
interface gf256mul_dec_if;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_val;
  logic [7:0] z;
  logic [7:0] z_q;
  logic       out_val;

  modport master (
    output a,
    output b,
    output in_val,
    input  z,
    input  z_q,
    input  out_val
  );

  modport slave (
    input  a,
    input  b,
    input  in_val,
    output z,
    output z_q,
    output out_val
  );
endinterface

// File: rtl/gf256mul_dec.sv
// GF(2^8) multiplier, field polynomial 0x11d; z is combinational, z_q/out_val are registered when GF256MUL_DEC_REG_EN is defined.
// Latency: z 0 cycles; z_q/out_val 1 cycle with GF256MUL_DEC_REG_EN, otherwise 0 cycles.
// No backpressure: a new operand pair is accepted every cycle.
module gf256mul_dec (
  input  logic           clk,
  input  logic           rst_n,
  gf256mul_dec_if.slave  bus
);

  logic [14:0] pp;
  logic [14:0] red;

  // Carry-less partial-product sum, then fold bits 14..8 back using x^8 = 0x1d.
  always_comb begin
    pp = '0;
    for (int i = 0; i < 8; i++) begin
      if (bus.b[i]) pp = pp ^ ({7'd0, bus.a} << i);
    end
    red = pp;
    for (int k = 14; k >= 8; k--) begin
      if (red[k]) red = red ^ (15'h11d << (k - 8));
    end
  end

  assign bus.z = red[7:0];

`ifdef GF256MUL_DEC_REG_EN
  logic       rel_q;
  logic [7:0] z_q_r;
  logic       out_val_r;

  // rel_q stays low through the first edge after reset release, so an
  // in_val pulse on that edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q     <= 1'b0;
      z_q_r     <= 8'h00;
      out_val_r <= 1'b0;
    end else begin
      rel_q     <= 1'b1;
      out_val_r <= bus.in_val & rel_q;
      if (bus.in_val && rel_q) z_q_r <= bus.z;
    end
  end

  assign bus.z_q     = z_q_r;
  assign bus.out_val = out_val_r;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst_n;
  assign bus.z_q        = bus.z;
  assign bus.out_val    = bus.in_val;
`endif

endmodule

// File: tb/tb_gf256mul_dec.sv
// Directed self-checking bench for gf256mul_dec; covers both builds of GF256MUL_DEC_REG_EN.
module tb_gf256mul_dec;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  gf256mul_dec_if bus ();

  gf256mul_dec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%02h expected=0x%02h", tag, got, exp);
    end
  endtask

  // Russian-peasant reference: xtime the multiplicand, shift the multiplier.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    logic [7:0] xx;
    logic [7:0] yy;
    r  = 8'h00;
    xx = x;
    yy = y;
    for (int i = 0; i < 8; i++) begin
      if (yy[0]) r = r ^ xx;
      xx = xx[7] ? ((xx << 1) ^ 8'h1d) : (xx << 1);
      yy = yy >> 1;
    end
    return r;
  endfunction

  logic [7:0] vec_a [4] = '{8'h02, 8'h80, 8'h03, 8'h8e};
  logic [7:0] vec_b [4] = '{8'h80, 8'h80, 8'h03, 8'h02};
  logic [7:0] vec_z [4] = '{8'h1d, 8'h13, 8'h05, 8'h01};
  logic [7:0] res [256][256];

  initial begin
    logic [7:0] p;
    logic [7:0] nxt;
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    bus.a      = 8'h00;
    bus.b      = 8'h00;
    bus.in_val = 1'b0;
    #2;

`ifdef GF256MUL_DEC_REG_EN
    chk("rst_z_q", bus.z_q, 8'h00);
    chk("rst_out_val", {7'd0, bus.out_val}, 8'h00);
    bus.a = 8'h02; bus.b = 8'h80; bus.in_val = 1'b1;
    #2;
    chk("rst_z_live", bus.z, 8'h1d);
    chk("rst_hold_z_q", bus.z_q, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_drop_vld", {7'd0, bus.out_val}, 8'h00);
    chk("rel_drop_z_q", bus.z_q, 8'h00);

    @(posedge clk); #1;
    chk("cap_vld", {7'd0, bus.out_val}, 8'h01);
    chk("cap_z_q", bus.z_q, 8'h1d);

    @(negedge clk);
    bus.in_val = 1'b0; bus.a = 8'h03; bus.b = 8'h03;
    @(posedge clk); #1;
    chk("hold_vld", {7'd0, bus.out_val}, 8'h00);
    chk("hold_z_q", bus.z_q, 8'h1d);

    @(negedge clk);
    bus.in_val = 1'b1; bus.a = 8'h80; bus.b = 8'h80;
    @(posedge clk); #1;
    chk("cap2_vld", {7'd0, bus.out_val}, 8'h01);
    chk("cap2_z_q", bus.z_q, 8'h13);

    @(negedge clk);
    bus.a = 8'h8e; bus.b = 8'h02;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_z_q", bus.z_q, 8'h00);
    chk("mid_rst_vld", {7'd0, bus.out_val}, 8'h00);
    chk("mid_rst_z", bus.z, 8'h01);
    @(posedge clk); #1;
    chk("mid_rst_no_vld", {7'd0, bus.out_val}, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel2_drop_vld", {7'd0, bus.out_val}, 8'h00);
    @(posedge clk); #1;
    chk("rel2_cap_vld", {7'd0, bus.out_val}, 8'h01);
    chk("rel2_cap_z_q", bus.z_q, 8'h01);
    bus.in_val = 1'b0;
`else
    for (int i = 0; i < 6; i++) begin
      logic iv;
      iv         = (i % 2) == 1;
      bus.in_val = iv;
      bus.a      = vec_a[i % 4];
      bus.b      = vec_b[i % 4];
      #2;
      chk("comb_out_val", {7'd0, bus.out_val}, {7'd0, iv});
      chk("comb_z_q", bus.z_q, vec_z[i % 4]);
    end
    rst_n = 1'b1;
    bus.a = 8'h03; bus.b = 8'h03;
    #2;
    chk("comb_rst_z", bus.z, 8'h05);
    bus.in_val = 1'b0;
`endif

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.a = vec_a[i]; bus.b = vec_b[i];
      #2;
      chk("ref_vec", bus.z, vec_z[i]);
    end

    for (int i = 0; i < 256; i++) begin
      bus.a = 8'(i); bus.b = 8'h01;
      #2;
      chk("ident", bus.z, 8'(i));
      bus.b = 8'h00;
      #2;
      chk("zero", bus.z, 8'h00);
    end

    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        bus.a = 8'(i); bus.b = 8'(j);
        #2;
        res[i][j] = bus.z;
        chk("exh", bus.z, ref_mul(8'(i), 8'(j)));
      end
    end
    for (int i = 0; i < 256; i++) begin
      for (int j = i + 1; j < 256; j++) begin
        chk("commute", res[i][j], res[j][i]);
      end
    end

    p = 8'h01;
    for (int s = 1; s <= 255; s++) begin
      bus.a = p; bus.b = 8'h02;
      #2;
      nxt = ref_mul(p, 8'h02);
      chk("pow_step", bus.z, nxt);
      if (s == 8)   chk("pow_alpha8", bus.z, 8'h1d);
      if (s == 14)  chk("pow_alpha14", bus.z, 8'h13);
      if (s == 255) chk("pow_wrap", bus.z, 8'h01);
      else          chk("pow_early_one", {7'd0, bus.z == 8'h01}, 8'h00);
      p = nxt;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
